dds_freq_meter: RTL and testbench

Measures the period of a sampled 8-bit unsigned sine stream, such as the DDS/sine-table output looped back or an external ADC capture, and reports it in samples per cycle. It is the receiving counterpart of the phase-to-amplitude path: a midscale Schmitt-trigger crossing detector feeds a period counter and an averaging accumulator. It is used for self-test of the tuning word and for frequency readback on the output pins.

---
 rtl/dds_freq_meter.sv | 96 +++++++++
 tb/tb_dds_freq_meter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_freq_meter.sv
// Period meter for an 8-bit unsigned sine stream: a midscale Schmitt trigger
// detects rising crossings, and periods between them are averaged over 2^AVG_LOG2 cycles.
module dds_freq_meter #(
  parameter int MID      = 128,
  parameter int HYST     = 8,
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam logic [7:0] RISE_TH = 8'(MID + HYST);
  localparam logic [7:0] FALL_TH = 8'(MID - HYST);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {LVL_UNKNOWN, LVL_LOW, LVL_HIGH} level_t;
  typedef enum logic {SEARCH, MEASURE} state_t;

  level_t              level;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] pcount;

  logic                above;
  logic                below;
  logic                rise;
  logic [CNT_W-1:0]    candidate;
  logic [ACC_W-1:0]    sum;

  // Only a LOW->HIGH transition counts; leaving UNKNOWN never produces an event.
  assign above     = (sample_in >= RISE_TH);
  assign below     = (sample_in <= FALL_TH);
  assign rise      = (level == LVL_LOW) && above;
  assign candidate = cnt + 1'b1;
  assign sum       = acc + ACC_W'(candidate);

  always_ff @(posedge clk) begin
    if (rst) begin
      level        <= LVL_UNKNOWN;
      state        <= SEARCH;
      cnt          <= '0;
      acc          <= '0;
      pcount       <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (sample_valid) begin
        if (above) begin
          level <= LVL_HIGH;
        end else if (below) begin
          level <= LVL_LOW;
        end

        // A saturated counter wins over any event on the same sample.
        if (cnt == CNT_MAX) begin
          overflow <= 1'b1;
          locked   <= 1'b0;
          state    <= SEARCH;
          acc      <= '0;
          pcount   <= '0;
          cnt      <= '0;
        end else if (rise) begin
          cnt <= '0;
          if (state == SEARCH) begin
            state <= MEASURE;
          end else if (&pcount) begin
            period_out   <= sum[ACC_W-1:AVG_LOG2];
            period_valid <= 1'b1;
            locked       <= 1'b1;
            overflow     <= 1'b0;
            acc          <= '0;
            pcount       <= '0;
          end else begin
            acc    <= sum;
            pcount <= pcount + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Scoreboard bench for dds_freq_meter: expected averaged periods are queued as
// stimulus is driven and popped whenever the meter reports.
module tb_dds_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sample_in = 8'd128;
  logic        sample_valid = 1'b0;
  logic [15:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        overflow;

  int total = 0;
  int bad = 0;
  int reportCount = 0;
  int expQ[$];
  logic lastValid = 1'b0;
  logic prevPv = 1'b0;

  always #5 clk = ~clk;

  dds_freq_meter dut (
    .clk(clk),
    .rst(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .period_out(period_out),
    .period_valid(period_valid),
    .locked(locked),
    .overflow(overflow)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every report must match the oldest queued expectation,
  // last exactly one cycle, and follow a clock edge that consumed a sample.
  always @(posedge clk) lastValid <= sample_valid;

  always @(negedge clk) begin
    if (period_valid) begin
      reportCount++;
      checkOutput("pv_after_valid_edge", int'(lastValid), 1);
      checkOutput("pv_single_cycle", int'(prevPv), 0);
      checkOutput("report_was_expected", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) checkOutput("period_out", int'(period_out), expQ.pop_front());
    end
    prevPv = period_valid;
  end

  task automatic applyStimulus(input logic [7:0] s, input logic v);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] sineVal(input int i);
    real r;
    r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 64.0);
    return 8'($rtoi(r + 0.5));
  endfunction

  // Whole periods of a 64-sample sine, optionally with an idle cycle between samples.
  task automatic sendSine(input int periods, input bit gap);
    for (int i = 0; i < periods * 64; i++) begin
      applyStimulus(sineVal(i), 1'b1);
      if (gap) applyStimulus(8'd0, 1'b0);
    end
  endtask

  // One square period starting with its rising sample.
  task automatic sendSquare(input int p);
    for (int i = 0; i < p; i++) applyStimulus((i < p - p / 2) ? 8'd255 : 8'd0, 1'b1);
  endtask

  task automatic sendConst(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(v, 1'b1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_queue_drained"}, expQ.size(), 0);
  endtask

  initial begin
    int base;

    // Reset state
    doReset();
    checkOutput("rst_period_out", int'(period_out), 0);
    checkOutput("rst_period_valid", int'(period_valid), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_overflow", int'(overflow), 0);

    // 64-sample sine: no report before the 5th rising event, then two reports of 64
    base = reportCount;
    expQ.push_back(64);
    expQ.push_back(64);
    sendSine(5, 1'b0);
    checkOutput("sine_no_early_report", reportCount - base, 0);
    checkOutput("sine_not_locked_yet", int'(locked), 0);
    sendSine(1, 1'b0);
    checkOutput("sine_first_report", reportCount - base, 1);
    checkOutput("sine_locked", int'(locked), 1);
    checkOutput("sine_overflow", int'(overflow), 0);
    sendSine(4, 1'b0);
    checkOutput("sine_second_report", reportCount - base, 2);
    checkIdle("sine");

    // Samples inside the hysteresis band never produce events
    doReset();
    base = reportCount;
    for (int i = 0; i < 1000; i++) applyStimulus(8'(121 + (i % 15)), 1'b1);
    checkOutput("hyst_no_report", reportCount - base, 0);
    checkOutput("hyst_locked", int'(locked), 0);
    checkOutput("hyst_overflow", int'(overflow), 0);

    // Square stream: average of 60,62,66,68 then truncating average of 61,61,61,62
    doReset();
    expQ.push_back(64);
    expQ.push_back(61);
    applyStimulus(8'd0, 1'b1);
    sendSquare(60);
    sendSquare(62);
    sendSquare(66);
    sendSquare(68);
    sendSquare(61);
    sendSquare(61);
    sendSquare(61);
    sendSquare(62);
    applyStimulus(8'd255, 1'b1);
    sendConst(8'd255, 3);
    checkIdle("square");
    checkOutput("square_hold_period", int'(period_out), 61);
    checkOutput("square_locked", int'(locked), 1);

    // Counter saturation: cnt is 3 here, reaches 65535 after 65532 more samples
    sendConst(8'd200, 65532);
    checkOutput("ovf_not_yet", int'(overflow), 0);
    applyStimulus(8'd200, 1'b1);
    checkOutput("ovf_set", int'(overflow), 1);
    checkOutput("ovf_unlocked", int'(locked), 0);
    checkOutput("ovf_period_held", int'(period_out), 61);

    // Recovery after overflow needs five fresh rising events
    base = reportCount;
    expQ.push_back(64);
    sendSine(5, 1'b0);
    checkOutput("ovf_still_sticky", int'(overflow), 1);
    checkOutput("ovf_no_early_report", reportCount - base, 0);
    sendSine(1, 1'b0);
    checkOutput("ovf_cleared", int'(overflow), 0);
    checkOutput("ovf_relocked", int'(locked), 1);
    checkIdle("ovf_recover");

    // Same sine with idle cycles interleaved
    doReset();
    base = reportCount;
    expQ.push_back(64);
    sendSine(6, 1'b1);
    checkOutput("gap_report", reportCount - base, 1);
    checkOutput("gap_locked", int'(locked), 1);
    checkIdle("gap");

    // Reset mid-measurement discards a partial average
    sendSine(3, 1'b0);
    doReset();
    checkOutput("midrst_period_out", int'(period_out), 0);
    checkOutput("midrst_period_valid", int'(period_valid), 0);
    checkOutput("midrst_locked", int'(locked), 0);
    checkOutput("midrst_overflow", int'(overflow), 0);
    base = reportCount;
    expQ.push_back(64);
    sendSine(5, 1'b0);
    checkOutput("midrst_no_early_report", reportCount - base, 0);
    sendSine(1, 1'b0);
    checkOutput("midrst_report", reportCount - base, 1);
    checkIdle("midrst");

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
